// File: rtl/tiny_cpu_pkg.sv
// tiny_cpu_pkg: opcode table, ALU source select and state encodings for tiny_cpu_param.
package tiny_cpu_pkg;

    localparam logic [3:0] OP_ADD_A  = 4'b0000;
    localparam logic [3:0] OP_MOV_AB = 4'b0001;
    localparam logic [3:0] OP_IN_A   = 4'b0010;
    localparam logic [3:0] OP_MOV_AI = 4'b0011;
    localparam logic [3:0] OP_MOV_BA = 4'b0100;
    localparam logic [3:0] OP_ADD_B  = 4'b0101;
    localparam logic [3:0] OP_IN_B   = 4'b0110;
    localparam logic [3:0] OP_MOV_BI = 4'b0111;
    localparam logic [3:0] OP_HALT   = 4'b1000;
    localparam logic [3:0] OP_OUT_B  = 4'b1001;
    localparam logic [3:0] OP_OUT_IM = 4'b1011;
    localparam logic [3:0] OP_JNC    = 4'b1110;
    localparam logic [3:0] OP_JMP    = 4'b1111;

    typedef enum logic [1:0] {SRC_A, SRC_B, SRC_IN, SRC_ZERO} src_e;

    typedef enum logic {ST_RUN, ST_HALT} state_e;

    // Every opcode is src + im; the source picks which operand feeds the adder.
    function automatic src_e op_src(input logic [3:0] op);
        return (op == OP_ADD_A || op == OP_MOV_BA)                   ? SRC_A  :
               (op == OP_MOV_AB || op == OP_ADD_B || op == OP_OUT_B) ? SRC_B  :
               (op == OP_IN_A || op == OP_IN_B)                      ? SRC_IN : SRC_ZERO;
    endfunction

endpackage

// File: rtl/tiny_cpu_alu.sv
// tiny_cpu_alu: 4:1 source mux feeding a DATA_W+1 bit adder with the immediate.
module tiny_cpu_alu
    import tiny_cpu_pkg::*;
#(
    parameter int DATA_W = 4
) (
    input  logic [1:0]        sel,
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [DATA_W-1:0] in_port,
    input  logic [DATA_W-1:0] im,
    output logic [DATA_W-1:0] res,
    output logic              c
);
    logic [DATA_W-1:0] src;

    // Select the source operand and add the immediate with carry out
    always_comb begin
        src      = sel == SRC_A ? a : sel == SRC_B ? b : sel == SRC_IN ? in_port : '0;
        {c, res} = {1'b0, src} + {1'b0, im};
    end

endmodule

// File: rtl/tiny_cpu_param.sv
// tiny_cpu_param: parametrised accumulator CPU core with fetch-valid stall and output strobe.
// Optional HALT opcode (1000) and HALT state are built when TINY_CPU_HALT_EN is defined.
module tiny_cpu_param
    import tiny_cpu_pkg::*;
#(
    parameter int DATA_W   = 4,
    parameter int ADDR_W   = 4,
    parameter int PC_RESET = 0
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              instr_valid,
    input  logic [DATA_W+3:0] instr,
    input  logic [DATA_W-1:0] in_port,
    output logic [ADDR_W-1:0] pc_addr,
    output logic [DATA_W-1:0] out_port,
    output logic              out_strobe,
    output logic              carry,
    output logic              halted
);
    logic [3:0]        op;
    logic [DATA_W-1:0] im;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [DATA_W-1:0] res;
    logic [1:0]        sel;
    logic              c_alu;
    logic              run;
    logic              is_halt;
    logic              exec;
    logic              take;
    logic              wr_a;
    logic              wr_b;
    logic              is_out;
    logic [ADDR_W-1:0] pc_nx;

    assign op  = instr[DATA_W+3:DATA_W];
    assign im  = instr[DATA_W-1:0];
    assign sel = op_src(op);

    tiny_cpu_alu #(.DATA_W(DATA_W)) u_alu (
        .sel    (sel),
        .a      (a),
        .b      (b),
        .in_port(in_port),
        .im     (im),
        .res    (res),
        .c      (c_alu)
    );

`ifdef TINY_CPU_HALT_EN
    state_e state;
    state_e state_nx;

    // State register: HALT is only left through reset
    always_ff @(posedge clk or negedge n_reset)
        if (!n_reset) state <= ST_RUN;
        else state <= state_nx;

    // Enter HALT when a HALT opcode executes in RUN
    always_comb begin
        state_nx = state;
        if (state == ST_RUN && instr_valid && op == OP_HALT) state_nx = ST_HALT;
    end

    assign run     = state == ST_RUN;
    assign halted  = state == ST_HALT;
    assign is_halt = op == OP_HALT;
`else
    assign run     = 1'b1;
    assign halted  = 1'b0;
    assign is_halt = 1'b0;
`endif

    // Decode: execute enable, destinations, branch decision and next PC
    always_comb begin
        exec   = run & instr_valid;
        wr_a   = op[3:2] == 2'b00;
        wr_b   = op[3:2] == 2'b01;
        is_out = op == OP_OUT_B || op == OP_OUT_IM;
        take   = op == OP_JMP || (op == OP_JNC && !carry);
        pc_nx  = is_halt ? pc_addr : take ? im[ADDR_W-1:0] : pc_addr + ADDR_W'(1);
    end

    // Architectural registers update only on executed instructions; strobe marks an OUT
    always_ff @(posedge clk or negedge n_reset)
        if (!n_reset) begin
            a          <= '0;
            b          <= '0;
            out_port   <= '0;
            carry      <= 1'b0;
            out_strobe <= 1'b0;
            pc_addr    <= ADDR_W'(PC_RESET);
        end else begin
            out_strobe <= exec & is_out;
            if (exec) begin
                if (wr_a) a <= res;
                if (wr_b) b <= res;
                if (is_out) out_port <= res;
                carry   <= c_alu;
                pc_addr <= pc_nx;
            end
        end

endmodule

// File: tb/tb_tiny_cpu_param.sv
// tb_tiny_cpu_param: directed bench for two tiny_cpu_param configurations checked against an opcode-level model.
module tb_tiny_cpu_param;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        valid;
    logic [7:0]  i4;
    logic [11:0] i8;
    logic [3:0]  p4;
    logic [7:0]  p8;
    logic [3:0]  pc4;
    logic [5:0]  pc8;
    logic [3:0]  out4;
    logic [7:0]  out8;
    logic        stb4, stb8, c4, c8, h4, h8;

    int checks = 0;
    int failures = 0;

    int dw[2] = '{4, 8};
    int aw[2] = '{4, 6};
    int pr[2] = '{0, 5};
    int m_a[2], m_b[2], m_pc[2], m_c[2], m_o[2], m_s[2], m_h[2];

    always #5 clk = ~clk;

    tiny_cpu_param u4 (
        .clk(clk), .n_reset(n_reset), .instr_valid(valid), .instr(i4), .in_port(p4),
        .pc_addr(pc4), .out_port(out4), .out_strobe(stb4), .carry(c4), .halted(h4)
    );

    tiny_cpu_param #(.DATA_W(8), .ADDR_W(6), .PC_RESET(5)) u8 (
        .clk(clk), .n_reset(n_reset), .instr_valid(valid), .instr(i8), .in_port(p8),
        .pc_addr(pc8), .out_port(out8), .out_strobe(stb8), .carry(c8), .halted(h8)
    );

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic mreset();
        for (int k = 0; k < 2; k++) begin
            m_a[k] = 0; m_b[k] = 0; m_c[k] = 0; m_o[k] = 0; m_s[k] = 0; m_h[k] = 0;
            m_pc[k] = pr[k];
        end
    endtask

    // Opcode-level semantics: result = src + im, destination by opcode group
    task automatic mstep(input int k, input int op, input int im, input int inp);
        int src, sum, halt;
        bit jmp;
        m_s[k] = 0;
        if (m_h[k] != 0 || !valid) return;
        src = (op == 0 || op == 4) ? m_a[k] :
              (op == 1 || op == 5 || op == 9) ? m_b[k] :
              (op == 2 || op == 6) ? inp : 0;
        sum = src + im;
        jmp = op == 15 || (op == 14 && m_c[k] == 0);
`ifdef TINY_CPU_HALT_EN
        halt = op == 8 ? 1 : 0;
`else
        halt = 0;
`endif
        if (op < 4) m_a[k] = sum % (1 << dw[k]);
        else if (op < 8) m_b[k] = sum % (1 << dw[k]);
        else if (op == 9 || op == 11) begin
            m_o[k] = sum % (1 << dw[k]);
            m_s[k] = 1;
        end
        m_c[k] = sum >> dw[k];
        m_pc[k] = halt != 0 ? m_pc[k] : jmp ? im % (1 << aw[k]) : (m_pc[k] + 1) % (1 << aw[k]);
        m_h[k] = halt;
    endtask

    always @(posedge clk or negedge n_reset)
        if (!n_reset) mreset();
        else begin
            mstep(0, int'(i4[7:4]), int'(i4[3:0]), int'(p4));
            mstep(1, int'(i8[11:8]), int'(i8[7:0]), int'(p8));
        end

    always @(negedge clk) begin
        check("pc4", 32'(pc4), m_pc[0]);
        check("out4", 32'(out4), m_o[0]);
        check("carry4", 32'(c4), m_c[0]);
        check("strobe4", 32'(stb4), m_s[0]);
        check("halted4", 32'(h4), m_h[0]);
        check("pc8", 32'(pc8), m_pc[1]);
        check("out8", 32'(out8), m_o[1]);
        check("carry8", 32'(c8), m_c[1]);
        check("strobe8", 32'(stb8), m_s[1]);
        check("halted8", 32'(h8), m_h[1]);
    end

    task automatic step(input logic v, input logic [7:0] x4, input logic [11:0] x8);
        valid = v;
        i4 = x4;
        i8 = x8;
        @(negedge clk);
    endtask

    initial begin
        n_reset = 1'b0;
        valid = 1'b0;
        i4 = 8'hA0;
        i8 = 12'hA00;
        p4 = 4'h0;
        p8 = 8'h00;
        repeat (2) @(negedge clk);
        check("lit_rst_pc4", 32'(pc4), 0);
        check("lit_rst_pc8", 32'(pc8), 5);
        check("lit_rst_out4", 32'(out4), 0);
        check("lit_rst_halted4", 32'(h4), 0);
        n_reset = 1'b1;

        step(1, 8'h35, 12'hA00);
        step(1, 8'h0C, 12'hA00);
        check("lit_add_carry", 32'(c4), 1);
        step(1, 8'hE9, 12'hA00);
        check("lit_jnc_not_taken", 32'(pc4), 3);
        step(1, 8'h40, 12'hA00);
        step(1, 8'h90, 12'hA00);
        check("lit_out_a", 32'(out4), 1);
        check("lit_strobe_a", 32'(stb4), 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 8'hFF, 12'hFFF);
            check("lit_stall_pc", 32'(pc4), 5);
            check("lit_stall_out", 32'(out4), 1);
            check("lit_stall_strobe", 32'(stb4), 0);
        end

        p4 = 4'b0101;
        step(1, 8'h60, 12'hA00);
        step(1, 8'h90, 12'hA00);
        check("lit_in_out", 32'(out4), 5);
        check("lit_in_strobe", 32'(stb4), 1);
        step(1, 8'hA0, 12'hA00);
        check("lit_strobe_drop", 32'(stb4), 0);
        check("lit_nop_pc", 32'(pc4), 8);
        step(1, 8'hE7, 12'hA00);
        check("lit_jnc_taken", 32'(pc4), 7);
        step(1, 8'hFF, 12'hA00);
        step(1, 8'hC0, 12'hA00);
        check("lit_pc_wrap", 32'(pc4), 0);
        step(1, 8'hB9, 12'hA00);
        check("lit_out_im9", 32'(out4), 9);
        step(1, 8'hB3, 12'hA00);
        check("lit_out_im3", 32'(out4), 3);
        check("lit_strobe_b2b", 32'(stb4), 1);

        step(1, 8'h10, 12'hA00);
        step(1, 8'h0F, 12'hA00);
        check("lit_mov_add_carry", 32'(c4), 1);
        step(1, 8'hE0, 12'hA00);
        check("lit_jnc_carry_set", 32'(pc4), 5);
        step(1, 8'h40, 12'hA00);
        step(1, 8'h5D, 12'hA00);
        check("lit_add_b_carry", 32'(c4), 1);
        step(1, 8'h90, 12'hA00);
        check("lit_out_b1", 32'(out4), 1);

        step(1, 8'hF3, 12'hA00);
        for (int i = 0; i < 3; i++) begin
            step(1, 8'hF3, 12'hA00);
            check("lit_self_loop", 32'(pc4), 3);
        end
        step(1, 8'h0F, 12'hA00);
        check("lit_pre_halt_carry", 32'(c4), 1);
        step(1, 8'h80, 12'hA00);
`ifdef TINY_CPU_HALT_EN
        check("lit_halted", 32'(h4), 1);
        check("lit_halt_pc", 32'(pc4), 4);
        check("lit_halt_carry", 32'(c4), 0);
        for (int i = 0; i < 4; i++) begin
            step(i[0], i[0] ? 8'hF9 : 8'h90, 12'hA00);
            check("lit_halt_hold_pc", 32'(pc4), 4);
            check("lit_halt_hold", 32'(h4), 1);
        end
`else
        check("lit_nop8_halted", 32'(h4), 0);
        check("lit_nop8_pc", 32'(pc4), 5);
        check("lit_nop8_carry", 32'(c4), 0);
`endif

        valid = 1'b0;
        #2 n_reset = 1'b0;
        #1;
        check("lit_async_halted", 32'(h4), 0);
        check("lit_async_pc4", 32'(pc4), 0);
        check("lit_async_pc8", 32'(pc8), 5);
        check("lit_async_out4", 32'(out4), 0);
        @(negedge clk);
        n_reset = 1'b1;

        step(1, 8'hA0, 12'h301);
        step(1, 8'hA0, 12'h0FF);
        check("lit_w8_carry", 32'(c8), 1);
        step(1, 8'hA0, 12'h400);
        step(1, 8'hA0, 12'h900);
        check("lit_w8_out0", 32'(out8), 0);
        check("lit_w8_strobe", 32'(stb8), 1);
        step(1, 8'hA0, 12'hF2A);
        check("lit_w8_jmp", 32'(pc8), 42);
        step(1, 8'hA0, 12'h380);
        step(1, 8'hA0, 12'h07F);
        check("lit_w8_nocarry", 32'(c8), 0);
        step(1, 8'hA0, 12'h400);
        step(1, 8'hA0, 12'h900);
        check("lit_w8_outff", 32'(out8), 255);
        step(1, 8'hA0, 12'hFFF);
        check("lit_w8_jmp_trunc", 32'(pc8), 63);
        step(1, 8'hA0, 12'hA00);
        check("lit_w8_wrap", 32'(pc8), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
